// File: rtl/maf_driver.sv
// maf_driver: issues operand triples to a multiply-add unit under a credit limit and returns results in order.
// Optional feature: define MAF_DRIVER_ERR_EN to add a sticky err output for results arriving with nothing in flight.
module maf_driver #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic             flush,
    output logic             maf_op_vld,
    output logic [WIDTH-1:0] maf_a,
    output logic [WIDTH-1:0] maf_b,
    output logic [WIDTH-1:0] maf_c,
    input  logic [WIDTH-1:0] maf_res,
    input  logic             maf_res_rdy,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_res,
    output logic             busy
`ifdef MAF_DRIVER_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    inflight_reg, inflight_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic             op_vld_reg;
    logic [WIDTH-1:0] a_reg, b_reg, c_reg;
    logic             busy_reg;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW:0]      credit_used;
    logic             accept;
    logic             res_valid;
    logic             push;
    logic             pop;

    // Every accepted operand owns one buffer slot until its result is popped,
    // so a push can never find the buffer full.
    assign credit_used = {1'b0, inflight_reg} + {1'b0, count_reg};
    assign in_rdy      = (state_reg != FLUSH) && !flush && (credit_used < DEPTH_C);
    assign accept      = in_vld && in_rdy;

    // A result with nothing in flight is stray and must not touch the buffer.
    assign res_valid   = maf_res_rdy && (inflight_reg != '0);
    assign push        = res_valid && (state_reg != FLUSH) && !flush;

    assign out_vld     = (count_reg != '0) && (state_reg != FLUSH);
    assign pop         = out_vld && out_rdy;
    assign out_res     = mem[rd_ptr_reg];

    assign maf_op_vld  = op_vld_reg;
    assign maf_a       = a_reg;
    assign maf_b       = b_reg;
    assign maf_c       = c_reg;
    assign busy        = busy_reg;

    always_comb begin
        inflight_next = inflight_reg;
        if (accept && !res_valid) begin
            inflight_next = inflight_reg + 1'b1;
        end else if (!accept && res_valid) begin
            inflight_next = inflight_reg - 1'b1;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_next = count_reg + 1'b1;
            end else if (!push && pop) begin
                count_next = count_reg - 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = FLUSH;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (!accept && (inflight_reg == '0) && (count_reg == '0)) begin
                        state_next = IDLE;
                    end
                end
                FLUSH: begin
                    // Stay here until every late result has been swallowed.
                    if (inflight_reg == '0) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            inflight_reg <= '0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            op_vld_reg   <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            c_reg        <= '0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= inflight_next;
            count_reg    <= count_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            op_vld_reg   <= accept;
            busy_reg     <= (state_next != IDLE);
            if (accept) begin
                a_reg <= in_a;
                b_reg <= in_b;
                c_reg <= in_c;
            end
        end
    end

    // Storage needs no reset: emptiness is carried entirely by count_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= maf_res;
        end
    end

`ifdef MAF_DRIVER_ERR_EN
    logic err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (maf_res_rdy && (inflight_reg == '0)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`endif

endmodule

// File: tb/tb_maf_driver.sv
// Self-checking bench for maf_driver: directed vector table, corner-case sequences and
// randomized traffic checked every cycle against a queue-based reference model.
module tb_maf_driver;

    localparam int W = 32;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_vld, in_rdy, flush;
    logic [W-1:0] in_a, in_b, in_c;
    logic         maf_op_vld;
    logic [W-1:0] maf_a, maf_b, maf_c;
    logic [W-1:0] maf_res;
    logic         maf_res_rdy;
    logic         out_vld, out_rdy;
    logic [W-1:0] out_res;
    logic         busy;
`ifdef MAF_DRIVER_ERR_EN
    logic         err;
`endif

    maf_driver #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .flush(flush),
        .maf_op_vld(maf_op_vld), .maf_a(maf_a), .maf_b(maf_b), .maf_c(maf_c),
        .maf_res(maf_res), .maf_res_rdy(maf_res_rdy),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_res(out_res),
        .busy(busy)
`ifdef MAF_DRIVER_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: counts, a queue for the result buffer and a mode number.
    int           m_inflight;
    logic [W-1:0] m_buf[$];
    int           m_mode;      // 0 idle, 1 running, 2 flushing
    logic         m_op_vld;
    logic [W-1:0] m_a, m_b, m_c;
    logic         m_err;

    // Emulated multiply-add unit: in-order, configurable latency.
    typedef struct {
        logic [W-1:0] v;
        int           t;
    } mres_t;
    mres_t mq[$];
    bit    auto_maf = 0;
    int    lat_lo = 1, lat_hi = 1;
    int    last_t = 0;

    logic         s_in_rdy, s_op_vld, s_out_vld, s_busy;
    logic [W-1:0] s_out_res;

    typedef struct {
        logic         in_vld;
        logic [W-1:0] a, b, c;
        logic         res_rdy;
        logic [W-1:0] res;
        logic         out_rdy;
        logic         flush;
        logic         e_in_rdy;
        logic         e_op_vld;
        logic         e_out_vld;
        logic [W-1:0] e_out_res;
        logic         e_busy;
    } vec_t;
    vec_t tbl [7];

    function automatic logic [W-1:0] fma(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        return a * b + c;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_inflight = 0;
        m_buf.delete();
        m_mode   = 0;
        m_op_vld = 1'b0;
        m_a = '0; m_b = '0; m_c = '0;
        m_err = 1'b0;
        mq.delete();
        last_t = 0;
    endtask

    // One clock: drive MAF return, check outputs at negedge, advance the model.
    task automatic cycle();
        logic e_in_rdy, e_out_vld, acc, rv, pp;
        int   nm;
        mres_t e;
        if (auto_maf) begin
            if (maf_op_vld) begin
                e.v = fma(maf_a, maf_b, maf_c);
                e.t = cyc + int'($urandom_range(lat_hi, lat_lo));
                if (e.t <= last_t) e.t = last_t + 1;
                last_t = e.t;
                mq.push_back(e);
            end
            if (mq.size() > 0 && mq[0].t <= cyc) begin
                maf_res_rdy = 1'b1;
                maf_res     = mq[0].v;
                void'(mq.pop_front());
            end else begin
                maf_res_rdy = 1'b0;
            end
        end
        @(negedge clk);
        s_in_rdy  = in_rdy;
        s_op_vld  = maf_op_vld;
        s_out_vld = out_vld;
        s_out_res = out_res;
        s_busy    = busy;
        e_in_rdy  = (m_mode != 2) && !flush && (m_inflight + m_buf.size() < D);
        e_out_vld = (m_buf.size() != 0) && (m_mode != 2);
        chk("in_rdy", s_in_rdy, e_in_rdy);
        chk("out_vld", s_out_vld, e_out_vld);
        if (e_out_vld) chk("out_res", s_out_res, m_buf[0]);
        chk("busy", s_busy, m_mode != 0);
        chk("maf_op_vld", s_op_vld, m_op_vld);
        chk("maf_abc", {maf_a, maf_b, maf_c}, {m_a, m_b, m_c});
`ifdef MAF_DRIVER_ERR_EN
        chk("err", err, m_err);
`endif
        acc = in_vld && e_in_rdy;
        rv  = maf_res_rdy && (m_inflight > 0);
        pp  = e_out_vld && out_rdy;
        if (maf_res_rdy && m_inflight == 0) m_err = 1'b1;
        if (flush)                                              nm = 2;
        else if (m_mode == 2)                                   nm = (m_inflight == 0) ? 0 : 2;
        else if (acc)                                           nm = 1;
        else if (m_mode == 1 && m_inflight == 0 && m_buf.size() == 0) nm = 0;
        else                                                    nm = m_mode;
        if (pp) void'(m_buf.pop_front());
        if (rv && m_mode != 2 && !flush) m_buf.push_back(maf_res);
        if (flush) m_buf.delete();
        m_inflight = m_inflight + int'(acc) - int'(rv);
        m_op_vld = acc;
        if (acc) begin
            m_a = in_a; m_b = in_b; m_c = in_c;
        end
        m_mode = nm;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reset asserted between edges so the outputs must clear without a clock.
    task automatic do_reset();
        in_vld = 0; flush = 0; maf_res_rdy = 0; out_rdy = 0;
        #2 rst = 1'b1;
        #1;
        chk("rst_op_vld", maf_op_vld, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_abc", {maf_a, maf_b, maf_c}, 0);
`ifdef MAF_DRIVER_ERR_EN
        chk("rst_err", err, 0);
`endif
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc += 2;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        in_vld = 0; flush = 0; out_rdy = 1;
        auto_maf = 1;
        do begin
            cycle();
            n++;
        end while (s_busy && n < budget);
        chk("drain_idle", s_busy, 0);
    endtask

    int n_acc, next_op, got, n;

    initial begin
        rst = 1'b1;
        in_vld = 0; in_a = '0; in_b = '0; in_c = '0;
        flush = 0; maf_res = '0; maf_res_rdy = 0; out_rdy = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Single operation, 1.0*2.0+3.0 = 5.0 in IEEE single.
        tbl[0] = '{1'b1, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[1] = '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1};
        tbl[2] = '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b1, 32'h40A00000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1};
        tbl[3] = '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40A00000, 1'b1};
        tbl[4] = '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40A00000, 1'b1};
        tbl[5] = '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1};
        tbl[6] = '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        for (int i = 0; i < 7; i++) begin
            in_vld = tbl[i].in_vld; in_a = tbl[i].a; in_b = tbl[i].b; in_c = tbl[i].c;
            maf_res_rdy = tbl[i].res_rdy; maf_res = tbl[i].res;
            out_rdy = tbl[i].out_rdy; flush = tbl[i].flush;
            cycle();
            chk($sformatf("tbl%0d_in_rdy", i), s_in_rdy, tbl[i].e_in_rdy);
            chk($sformatf("tbl%0d_op_vld", i), s_op_vld, tbl[i].e_op_vld);
            chk($sformatf("tbl%0d_out_vld", i), s_out_vld, tbl[i].e_out_vld);
            if (tbl[i].e_out_vld) chk($sformatf("tbl%0d_out_res", i), s_out_res, tbl[i].e_out_res);
            chk($sformatf("tbl%0d_busy", i), s_busy, tbl[i].e_busy);
        end

        // Credit limit: consumer stalled, MAF answers every op after one cycle.
        auto_maf = 1; lat_lo = 1; lat_hi = 1;
        n_acc = 0;
        in_vld = 1; out_rdy = 0; flush = 0;
        for (int i = 0; i < 20; i++) begin
            in_a = i; in_b = 2; in_c = 1;
            cycle();
            if (s_in_rdy) n_acc++;
        end
        chk("credit_accepts", n_acc, D);
        chk("credit_full_rdy", s_in_rdy, 0);
        out_rdy = 1; cycle();
        chk("credit_pop_cycle_rdy", s_in_rdy, 0);
        out_rdy = 0; cycle();
        chk("credit_after_pop_rdy", s_in_rdy, 1);
        drain(100);

        // Ordering: 20 tagged ops, latency 3, random back-pressure.
        lat_lo = 3; lat_hi = 3;
        next_op = 0; got = 0;
        for (int i = 0; i < 1000 && got < 20; i++) begin
            in_vld  = (next_op < 20) && ($urandom_range(0, 3) != 0);
            in_a    = next_op; in_b = 3; in_c = next_op + 1000;
            out_rdy = $urandom_range(0, 1) == 1;
            cycle();
            if (in_vld && s_in_rdy) next_op++;
            if (s_out_vld && out_rdy) begin
                chk($sformatf("order_res%0d", got), s_out_res, fma(got, 3, got + 1000));
                got++;
            end
        end
        chk("order_count", got, 20);
        drain(100);

        // Accept with result in one cycle, then push with pop in one cycle.
        auto_maf = 0; maf_res_rdy = 0; out_rdy = 0;
        in_vld = 1; in_a = 11; in_b = 1; in_c = 2; cycle();
        in_a = 12; maf_res_rdy = 1; maf_res = 32'hA0; cycle();
        in_vld = 0; maf_res = 32'hA1; out_rdy = 1; cycle();
        chk("simul_head0", s_out_res, 32'hA0);
        maf_res_rdy = 0; cycle();
        chk("simul_vld", s_out_vld, 1);
        chk("simul_head1", s_out_res, 32'hA1);
        out_rdy = 0; cycle(); cycle();
        chk("simul_idle", s_busy, 0);

        // Flush with 3 in flight and 2 buffered.
        in_vld = 1;
        for (int i = 0; i < 5; i++) begin
            in_a = 20 + i; cycle();
        end
        in_vld = 0; maf_res_rdy = 1;
        for (int i = 0; i < 2; i++) begin
            maf_res = 32'hB0 + i; cycle();
        end
        maf_res_rdy = 0; flush = 1; cycle();
        flush = 0; in_vld = 1; cycle();
        chk("flush_out_vld", s_out_vld, 0);
        chk("flush_busy", s_busy, 1);
        chk("flush_in_rdy", s_in_rdy, 0);
        in_vld = 0; out_rdy = 1; maf_res_rdy = 1;
        for (int i = 0; i < 3; i++) begin
            maf_res = 32'hC0 + i; cycle();
            chk($sformatf("flush_late%0d_vld", i), s_out_vld, 0);
        end
        maf_res_rdy = 0; out_rdy = 0;
        n = 0;
        do begin
            cycle();
            n++;
        end while (s_busy && n < 5);
        chk("flush_idle", s_busy, 0);
        chk("flush_empty", s_out_vld, 0);

        // Stray result while nothing is in flight.
        maf_res_rdy = 1; maf_res = 32'hDEADBEEF; cycle();
        maf_res_rdy = 0; cycle();
        chk("spur_out_vld", s_out_vld, 0);
        chk("spur_busy", s_busy, 0);
`ifdef MAF_DRIVER_ERR_EN
        chk("spur_err", err, 1);
        cycle(); cycle();
        chk("spur_err_hold", err, 1);
`endif

        // Reset mid-operation, then a late result must be ignored.
        in_vld = 1; in_a = 5; cycle(); cycle(); in_vld = 0;
        do_reset();
        maf_res_rdy = 1; maf_res = 32'h77; cycle();
        maf_res_rdy = 0; cycle();
        chk("late_out_vld", s_out_vld, 0);
        chk("late_busy", s_busy, 0);
`ifdef MAF_DRIVER_ERR_EN
        chk("late_err", err, 1);
`endif
        do_reset();

        // Random traffic with occasional flushes and variable latency.
        auto_maf = 1; lat_lo = 1; lat_hi = 5;
        for (int i = 0; i < 800; i++) begin
            in_vld  = $urandom_range(0, 1) == 1;
            in_a    = $urandom; in_b = $urandom; in_c = $urandom;
            out_rdy = $urandom_range(0, 3) != 0;
            flush   = $urandom_range(0, 59) == 0;
            cycle();
        end
        drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/maf_driver.md
MAF_DRIVER -- requirements
Module: maf_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and result bit width.
REQ-002 The block SHALL have parameter DEPTH, default 8: result buffer entries and maximum credits (power of two, 2..64).
REQ-003 The block SHALL have port clk  input  1  sole clock; all logic samples on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have ports in_vld  input  1, in_rdy  output  1, and in_a/in_b/in_c  input  WIDTH: operand triple with valid/ready handshake.
REQ-006 The block SHALL have port flush  input  1  one-cycle request to discard all pending work.
REQ-007 The block SHALL have ports maf_op_vld  output  1 and maf_a/maf_b/maf_c  output  WIDTH: issue to the multiply-add unit.
REQ-008 The block SHALL have ports maf_res  input  WIDTH and maf_res_rdy  input  1: result return from the multiply-add unit.
REQ-009 The block SHALL have ports out_vld  output  1, out_rdy  input  1, and out_res  output  WIDTH: result stream with valid/ready handshake.
REQ-010 The block SHALL have port busy  output  1: high while state is not IDLE.

Function
REQ-011 The block SHALL use states IDLE, RUN and FLUSH.
- IDLE->RUN: on an input accept.
- RUN->IDLE: when inflight==0 and buffer empty.
- Any state->FLUSH: when flush=1.
- FLUSH->IDLE: when inflight==0.
REQ-012 Accept SHALL occur when in_vld && in_rdy.
REQ-013 in_rdy SHALL be asserted when state!=FLUSH and flush==0 and (inflight + buf_count) < DEPTH, computed from registered values.
REQ-014 On accept, maf_op_vld SHALL be 1 for exactly the next cycle, and maf_a/b/c SHALL be registered copies of in_a/b/c held until the next accept.
REQ-015 inflight SHALL increment on accept and decrement on maf_res_rdy; when both occur in the same cycle it SHALL be unchanged.
REQ-016 maf_res_rdy SHALL push maf_res into the in-order result FIFO in RUN/IDLE; in FLUSH the result SHALL be discarded but still decrement inflight.
REQ-017 out_vld SHALL equal buffer non-empty with state!=FLUSH, and out_res SHALL show the head entry (show-ahead); pop SHALL occur on out_vld && out_rdy.
REQ-018 Simultaneous push and pop SHALL leave buf_count unchanged.
- The credit rule SHALL guarantee no push when full.
- Pointers SHALL wrap modulo DEPTH.
REQ-019 Entering FLUSH SHALL empty the buffer in that cycle, and an accept SHALL NOT occur in the flush cycle.
REQ-020 Results SHALL leave in the same order as operands were accepted, and the block SHALL impose no fixed MAF latency.

Reset
REQ-021 Asserting rst SHALL immediately force state IDLE, inflight=0, buffer empty, pointers 0, maf_op_vld=0, maf_a/b/c=0, out_vld=0, busy=0.
REQ-022 A reset mid-operation SHALL drop all pending operands and results, and maf_res_rdy arriving after reset release SHALL be handled per REQ-023.
REQ-023 maf_res_rdy while inflight==0 SHALL be ignored and SHALL NOT push.

Configuration
REQ-024 When MAF_DRIVER_ERR_EN is defined, the block SHALL add port err  output  1, a sticky flag set by maf_res_rdy while inflight==0 and cleared only by rst.
REQ-025 When MAF_DRIVER_ERR_EN is undefined, port err SHALL be absent and REQ-023 SHALL still apply silently.

Verification
REQ-026 The bench SHALL cover all of the following scenarios:
- Single op: accept a=1.0 b=2.0 c=3.0 (IEEE single) -> maf_op_vld pulses 1 cycle next cycle; after maf_res_rdy with 0x40A00000, out_res=0x40A00000 with out_vld=1.
- Credit limit: DEPTH=8, out_rdy=0, MAF returning every op -> exactly 8 accepts, then in_rdy=0; one pop -> in_rdy=1 the next cycle.
- Ordering: 20 ops with MAF latency 3 and random out_rdy -> results emerge in order 0..19, none lost or duplicated.
- Simultaneous events: accept and maf_res_rdy in the same cycle -> inflight unchanged; push and pop in the same cycle -> buf_count unchanged.
- Flush: 3 inflight plus 2 buffered, flush=1 -> out_vld=0 next cycle, the 3 late results are discarded, IDLE after the last one, busy=0.
- Spurious result: maf_res_rdy with inflight==0 -> no out_vld; with MAF_DRIVER_ERR_EN, err=1 and held until rst.
